// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and decode types for the ID/EX ALU issue stage.
package alu_issue_stage_pkg;

  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned ALU_OP_LENGTH  = 4;
  localparam int unsigned LUI_SHIFT      = 16;

  localparam logic [WORD_WIDTH-1:0] ZEROWORD = '0;

  // ALU operation codes consumed by the execute-stage ALU.
  localparam logic [ALU_OP_LENGTH-1:0] ALU_ADD      = 4'd0;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_SUB      = 4'd1;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_AND      = 4'd2;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_XOR      = 4'd3;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_NOR      = 4'd4;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OR       = 4'd5;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_EQB      = 4'd6;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_SLT      = 4'd7;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_SLTU     = 4'd8;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_LS_LEFT  = 4'd9;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_LS_RIGHT = 4'd10;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_AS_RIGHT = 4'd11;

  // MIPS primary opcodes.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // MIPS R-type function codes.
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } imm_ext_e;

  typedef enum logic [1:0] {
    SRCA_RS    = 2'd0,
    SRCA_SHAMT = 2'd1,
    SRCA_LUI   = 2'd2
  } srca_sel_e;

  typedef enum logic {
    SRCB_RT  = 1'b0,
    SRCB_IMM = 1'b1
  } srcb_sel_e;

  // Decoded control bundle produced by alu_op_encoder.
  typedef struct packed {
    logic [ALU_OP_LENGTH-1:0] op;
    imm_ext_e                 ext;
    srca_sel_e                srca_sel;
    srcb_sel_e                srcb_sel;
    logic                     waddr_rd;
    logic                     wen;
    logic                     mem_read;
    logic                     mem_write;
    logic                     illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_encoder.sv
// Combinational decode of MIPS opcode/funct into ALU op, operand selects and control bits.
module alu_op_encoder
  import alu_issue_stage_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec_c
);

  // Unknown encodings fall through to EQB with the illegal flag and no write-back.
  always_comb begin
    dec_c          = '0;
    dec_c.op       = ALU_ADD;
    dec_c.ext      = EXT_SIGN;
    dec_c.srca_sel = SRCA_RS;
    dec_c.srcb_sel = SRCB_RT;
    case (opcode)
      OP_RTYPE: begin
        dec_c.waddr_rd = 1'b1;
        dec_c.wen      = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: dec_c.op = ALU_ADD;
          FN_SUB, FN_SUBU: dec_c.op = ALU_SUB;
          FN_AND:          dec_c.op = ALU_AND;
          FN_OR:           dec_c.op = ALU_OR;
          FN_XOR:          dec_c.op = ALU_XOR;
          FN_NOR:          dec_c.op = ALU_NOR;
          FN_SLT:          dec_c.op = ALU_SLT;
          FN_SLTU:         dec_c.op = ALU_SLTU;
          FN_SLL: begin
            dec_c.op       = ALU_LS_LEFT;
            dec_c.srca_sel = SRCA_SHAMT;
          end
          FN_SRL: begin
            dec_c.op       = ALU_LS_RIGHT;
            dec_c.srca_sel = SRCA_SHAMT;
          end
          FN_SRA: begin
            dec_c.op       = ALU_AS_RIGHT;
            dec_c.srca_sel = SRCA_SHAMT;
          end
          FN_SLLV:         dec_c.op = ALU_LS_LEFT;
          FN_SRLV:         dec_c.op = ALU_LS_RIGHT;
          FN_SRAV:         dec_c.op = ALU_AS_RIGHT;
          default: begin
            dec_c.op      = ALU_EQB;
            dec_c.wen     = 1'b0;
            dec_c.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec_c.srcb_sel = SRCB_IMM;
        dec_c.wen      = 1'b1;
      end
      OP_ANDI: begin
        dec_c.op       = ALU_AND;
        dec_c.ext      = EXT_ZERO;
        dec_c.srcb_sel = SRCB_IMM;
        dec_c.wen      = 1'b1;
      end
      OP_ORI: begin
        dec_c.op       = ALU_OR;
        dec_c.ext      = EXT_ZERO;
        dec_c.srcb_sel = SRCB_IMM;
        dec_c.wen      = 1'b1;
      end
      OP_XORI: begin
        dec_c.op       = ALU_XOR;
        dec_c.ext      = EXT_ZERO;
        dec_c.srcb_sel = SRCB_IMM;
        dec_c.wen      = 1'b1;
      end
      OP_SLTI: begin
        dec_c.op       = ALU_SLT;
        dec_c.srcb_sel = SRCB_IMM;
        dec_c.wen      = 1'b1;
      end
      OP_SLTIU: begin
        dec_c.op       = ALU_SLTU;
        dec_c.srcb_sel = SRCB_IMM;
        dec_c.wen      = 1'b1;
      end
      OP_LUI: begin
        dec_c.op       = ALU_LS_LEFT;
        dec_c.ext      = EXT_ZERO;
        dec_c.srca_sel = SRCA_LUI;
        dec_c.srcb_sel = SRCB_IMM;
        dec_c.wen      = 1'b1;
      end
      OP_LW: begin
        dec_c.srcb_sel = SRCB_IMM;
        dec_c.wen      = 1'b1;
        dec_c.mem_read = 1'b1;
      end
      OP_SW: begin
        dec_c.srcb_sel  = SRCB_IMM;
        dec_c.mem_write = 1'b1;
      end
      default: begin
        dec_c.op      = ALU_EQB;
        dec_c.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: resolves operands, encodes the ALU op and registers the execute-stage inputs.
// Build option ISSUE_FWD_EN: when defined, rs/rt are forwarded from MEM/WB; when undefined,
// operands come from the register file only and every RAW hazard raises stall_req_o.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned DW = WORD_WIDTH,
  parameter int unsigned RW = REG_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_d,
  input  logic [5:0]               opcode_d,
  input  logic [5:0]               funct_d,
  input  logic [4:0]               shamt_d,
  input  logic [15:0]              imm_d,
  input  logic [RW-1:0]            rs_d,
  input  logic [RW-1:0]            rt_d,
  input  logic [RW-1:0]            rd_d,
  input  logic [DW-1:0]            rs_data_d,
  input  logic [DW-1:0]            rt_data_d,
  input  logic                     mem_wen,
  input  logic                     wb_wen,
  input  logic [RW-1:0]            mem_waddr,
  input  logic [RW-1:0]            wb_waddr,
  input  logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            wb_wdata,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic                     stall_req_o,
  output logic [ALU_OP_LENGTH-1:0] aluOpE,
  output logic [DW-1:0]            SrcA,
  output logic [DW-1:0]            SrcB,
  output logic [DW-1:0]            store_data_e,
  output logic [RW-1:0]            waddr_e,
  output logic                     wen_e,
  output logic                     mem_read_e,
  output logic                     mem_write_e,
  output logic                     valid_e,
  output logic                     illegal_e
);

  dec_t          dec_c;
  logic [DW-1:0] rs_val_c;
  logic [DW-1:0] rt_val_c;
  logic [DW-1:0] imm_ext_c;
  logic [DW-1:0] srca_c;
  logic [DW-1:0] srcb_c;
  logic [RW-1:0] waddr_c;
  logic          wen_c;
  logic          mem_hit_rs_c;
  logic          mem_hit_rt_c;
  logic          wb_hit_rs_c;
  logic          wb_hit_rt_c;
  logic          load_use_c;
  logic          kill_c;
  logic          load_c;

  alu_op_encoder u_encoder (
    .opcode (opcode_d),
    .funct  (funct_d),
    .dec_c  (dec_c)
  );

  // Address matches against the MEM/WB write ports and the load in E; register 0 never matches.
  always_comb begin
    mem_hit_rs_c = mem_wen && (mem_waddr != '0) && (mem_waddr == rs_d);
    mem_hit_rt_c = mem_wen && (mem_waddr != '0) && (mem_waddr == rt_d);
    wb_hit_rs_c  = wb_wen && (wb_waddr != '0) && (wb_waddr == rs_d);
    wb_hit_rt_c  = wb_wen && (wb_waddr != '0) && (wb_waddr == rt_d);
    load_use_c   = valid_d && valid_e && mem_read_e && (waddr_e != '0) &&
                   ((waddr_e == rs_d) || (waddr_e == rt_d));
  end

`ifdef ISSUE_FWD_EN
  // Operand resolution: the younger MEM result wins over WB, then the register file.
  always_comb begin
    rs_val_c = rs_data_d;
    rt_val_c = rt_data_d;
    if (mem_hit_rs_c)     rs_val_c = mem_wdata;
    else if (wb_hit_rs_c) rs_val_c = wb_wdata;
    if (mem_hit_rt_c)     rt_val_c = mem_wdata;
    else if (wb_hit_rt_c) rt_val_c = wb_wdata;
  end

  // Only a load in E cannot be covered by forwarding.
  always_comb stall_req_o = load_use_c;
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^{mem_wdata, wb_wdata};

  // Register file is the sole operand source.
  always_comb begin
    rs_val_c = rs_data_d;
    rt_val_c = rt_data_d;
  end

  // Any in-flight producer of rs/rt must drain before the consumer issues.
  always_comb begin
    stall_req_o = load_use_c ||
                  (valid_d && (mem_hit_rs_c || mem_hit_rt_c || wb_hit_rs_c || wb_hit_rt_c)) ||
                  (valid_d && valid_e && wen_e && (waddr_e != '0) &&
                   ((waddr_e == rs_d) || (waddr_e == rt_d)));
  end
`endif

  // Operand and destination selection for the instruction in ID.
  always_comb begin
    imm_ext_c = (dec_c.ext == EXT_SIGN) ? DW'($signed(imm_d)) : DW'(imm_d);
    case (dec_c.srca_sel)
      SRCA_SHAMT: srca_c = DW'(shamt_d);
      SRCA_LUI:   srca_c = DW'(LUI_SHIFT);
      default:    srca_c = rs_val_c;
    endcase
    srcb_c  = (dec_c.srcb_sel == SRCB_IMM) ? imm_ext_c : rt_val_c;
    waddr_c = dec_c.waddr_rd ? rd_d : rt_d;
    wen_c   = dec_c.wen && (waddr_c != '0);
  end

  // Edge action priority: flush, then hold, then load-use bubble, then normal load.
  always_comb begin
    kill_c = flush_i || (!stall_i && stall_req_o);
    load_c = !flush_i && !stall_i && !stall_req_o;
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluOpE       <= ALU_ADD;
      SrcA         <= '0;
      SrcB         <= '0;
      store_data_e <= '0;
      waddr_e      <= '0;
      wen_e        <= 1'b0;
      mem_read_e   <= 1'b0;
      mem_write_e  <= 1'b0;
      valid_e      <= 1'b0;
      illegal_e    <= 1'b0;
    end else if (kill_c) begin
      wen_e        <= 1'b0;
      mem_read_e   <= 1'b0;
      mem_write_e  <= 1'b0;
      valid_e      <= 1'b0;
      illegal_e    <= 1'b0;
    end else if (load_c) begin
      aluOpE       <= dec_c.op;
      SrcA         <= srca_c;
      SrcB         <= srcb_c;
      store_data_e <= rt_val_c;
      waddr_e      <= waddr_c;
      wen_e        <= valid_d && wen_c;
      mem_read_e   <= valid_d && dec_c.mem_read;
      mem_write_e  <= valid_d && dec_c.mem_write;
      valid_e      <= valid_d;
      illegal_e    <= valid_d && dec_c.illegal;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: reference model + scoreboard queue of expected E state.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_d;
  logic [5:0]  opcode_d;
  logic [5:0]  funct_d;
  logic [4:0]  shamt_d;
  logic [15:0] imm_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [31:0] rs_data_d, rt_data_d;
  logic        mem_wen, wb_wen;
  logic [4:0]  mem_waddr, wb_waddr;
  logic [31:0] mem_wdata, wb_wdata;
  logic        stall_i, flush_i;
  logic        stall_req_o;
  logic [3:0]  aluOpE;
  logic [31:0] SrcA, SrcB, store_data_e;
  logic [4:0]  waddr_e;
  logic        wen_e, mem_read_e, mem_write_e, valid_e, illegal_e;

`ifdef ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .opcode_d(opcode_d), .funct_d(funct_d),
    .shamt_d(shamt_d), .imm_d(imm_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .rs_data_d(rs_data_d), .rt_data_d(rt_data_d), .mem_wen(mem_wen), .wb_wen(wb_wen),
    .mem_waddr(mem_waddr), .wb_waddr(wb_waddr), .mem_wdata(mem_wdata), .wb_wdata(wb_wdata),
    .stall_i(stall_i), .flush_i(flush_i), .stall_req_o(stall_req_o), .aluOpE(aluOpE),
    .SrcA(SrcA), .SrcB(SrcB), .store_data_e(store_data_e), .waddr_e(waddr_e), .wen_e(wen_e),
    .mem_read_e(mem_read_e), .mem_write_e(mem_write_e), .valid_e(valid_e), .illegal_e(illegal_e)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [4:0]  waddr;
    logic        wen;
    logic        mr;
    logic        mw;
    logic        valid;
    logic        ill;
  } estate_t;

  estate_t m;
  estate_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] r_opc   [12] = '{6'h00, 6'h00, 6'h00, 6'h09, 6'h08, 6'h0C, 6'h0D, 6'h0E,
                               6'h0A, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] r_funct [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h3F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd_val(input logic [4:0] r, input logic [31:0] rf);
    if (FWD && mem_wen && mem_waddr != 5'd0 && mem_waddr == r) return mem_wdata;
    if (FWD && wb_wen && wb_waddr != 5'd0 && wb_waddr == r) return wb_wdata;
    return rf;
  endfunction

  function automatic logic hit(input logic en, input logic [4:0] a);
    return en && a != 5'd0 && (a == rs_d || a == rt_d);
  endfunction

  function automatic logic model_stall();
    logic s;
    s = valid_d && m.valid && m.mr && hit(1'b1, m.waddr);
    if (!FWD && valid_d && (hit(mem_wen, mem_waddr) || hit(wb_wen, wb_waddr) ||
                            hit(m.valid && m.wen, m.waddr)))
      s = 1'b1;
    return s;
  endfunction

  function automatic estate_t clear_ctl(input estate_t e);
    estate_t r;
    r = e;
    r.wen = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.valid = 1'b0; r.ill = 1'b0;
    return r;
  endfunction

  // Expected E contents for the instruction currently on the ID inputs.
  function automatic estate_t encode();
    estate_t e;
    logic [31:0] sx, zx, rtv;
    sx  = {{16{imm_d[15]}}, imm_d};
    zx  = {16'h0000, imm_d};
    rtv = fwd_val(rt_d, rt_data_d);
    e = '0;
    e.valid = 1'b1; e.a = fwd_val(rs_d, rs_data_d); e.b = rtv; e.st = rtv; e.wen = 1'b1;
    if (opcode_d == 6'h00) begin
      e.waddr = rd_d;
      case (funct_d)
        6'h20, 6'h21: e.op = 4'd0;
        6'h22, 6'h23: e.op = 4'd1;
        6'h24: e.op = 4'd2;
        6'h25: e.op = 4'd5;
        6'h26: e.op = 4'd3;
        6'h27: e.op = 4'd4;
        6'h2A: e.op = 4'd7;
        6'h2B: e.op = 4'd8;
        6'h00: begin e.op = 4'd9;  e.a = {27'd0, shamt_d}; end
        6'h02: begin e.op = 4'd10; e.a = {27'd0, shamt_d}; end
        6'h03: begin e.op = 4'd11; e.a = {27'd0, shamt_d}; end
        6'h04: e.op = 4'd9;
        6'h06: e.op = 4'd10;
        6'h07: e.op = 4'd11;
        default: begin e.op = 4'd6; e.wen = 1'b0; e.ill = 1'b1; end
      endcase
    end else begin
      e.waddr = rt_d;
      case (opcode_d)
        6'h08, 6'h09: begin e.op = 4'd0; e.b = sx; end
        6'h0C: begin e.op = 4'd2; e.b = zx; end
        6'h0D: begin e.op = 4'd5; e.b = zx; end
        6'h0E: begin e.op = 4'd3; e.b = zx; end
        6'h0A: begin e.op = 4'd7; e.b = sx; end
        6'h0B: begin e.op = 4'd8; e.b = sx; end
        6'h0F: begin e.op = 4'd9; e.a = 32'd16; e.b = zx; end
        6'h23: begin e.op = 4'd0; e.b = sx; e.mr = 1'b1; end
        6'h2B: begin e.op = 4'd0; e.b = sx; e.mw = 1'b1; e.wen = 1'b0; end
        default: begin e.op = 4'd6; e.wen = 1'b0; e.ill = 1'b1; end
      endcase
    end
    if (e.waddr == 5'd0) e.wen = 1'b0;
    if (!valid_d) e = clear_ctl(e);
    return e;
  endfunction

  task automatic compare_e(input estate_t e);
    check("valid_e", 32'(valid_e), 32'(e.valid));
    check("wen_e", 32'(wen_e), 32'(e.wen));
    check("mem_read_e", 32'(mem_read_e), 32'(e.mr));
    check("mem_write_e", 32'(mem_write_e), 32'(e.mw));
    check("illegal_e", 32'(illegal_e), 32'(e.ill));
    if (e.valid) check("aluOpE", 32'(aluOpE), 32'(e.op));
    if (e.valid && !e.ill) begin
      check("SrcA", SrcA, e.a);
      check("SrcB", SrcB, e.b);
      check("store_data_e", store_data_e, e.st);
      check("waddr_e", 32'(waddr_e), 32'(e.waddr));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_op"}, 32'(aluOpE), 32'd0);
    check({tag, "_srca"}, SrcA, 32'd0);
    check({tag, "_srcb"}, SrcB, 32'd0);
    check({tag, "_store"}, store_data_e, 32'd0);
    check({tag, "_ctl"}, 32'({waddr_e, wen_e, mem_read_e, mem_write_e, valid_e, illegal_e}), 32'd0);
  endtask

  // One ID->E edge: check the stall request, push the expected E state, pop and compare after the edge.
  task automatic step();
    logic exp_stall;
    estate_t exp;
    #1;
    exp_stall = model_stall();
    check("stall_req_o", 32'(stall_req_o), 32'(exp_stall));
    if (flush_i)        m = clear_ctl(m);
    else if (stall_i)   m = m;
    else if (exp_stall) m = clear_ctl(m);
    else                m = encode();
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    compare_e(exp);
  endtask

  task automatic set_instr(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [15:0] im, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
    valid_d = 1'b1; opcode_d = opc; funct_d = fn; shamt_d = sh; imm_d = im;
    rs_d = rs; rt_d = rt; rd_d = rd; rs_data_d = rsd; rt_data_d = rtd;
  endtask

  task automatic clear_fwd();
    mem_wen = 1'b0; wb_wen = 1'b0; mem_waddr = 5'd0; wb_waddr = 5'd0;
    mem_wdata = 32'd0; wb_wdata = 32'd0;
  endtask

  initial begin
    rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    set_instr(6'h00, 6'h20, 5'd0, 16'h0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    valid_d = 1'b0;
    clear_fwd();
    m = '0;
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADDIU with sign-extended all-ones immediate
    set_instr(6'h09, 6'h00, 5'd0, 16'hFFFF, 5'd1, 5'd2, 5'd0, 32'd5, 32'd0);
    step();
    check("addiu_srca", SrcA, 32'd5);
    check("addiu_srcb", SrcB, 32'hFFFF_FFFF);
    check("addiu_waddr", 32'(waddr_e), 32'd2);

    // SRA: shamt on SrcA, shifted value on SrcB
    set_instr(6'h00, 6'h03, 5'd4, 16'h0, 5'd0, 5'd7, 5'd5, 32'd0, 32'h8000_0000);
    step();
    check("sra_op", 32'(aluOpE), 32'd11);
    check("sra_srca", SrcA, 32'd4);

    // LUI
    set_instr(6'h0F, 6'h00, 5'd0, 16'h1234, 5'd0, 5'd6, 5'd0, 32'd0, 32'd0);
    step();
    check("lui_srca", SrcA, 32'd16);
    check("lui_srcb", SrcB, 32'h0000_1234);

    // Forwarding: both hit rs=3, then only WB, then a hit on register 0
    set_instr(6'h00, 6'h20, 5'd0, 16'h0, 5'd3, 5'd4, 5'd10, 32'h11, 32'h22);
    mem_wen = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'hAA;
    wb_wen  = 1'b1; wb_waddr  = 5'd3; wb_wdata  = 32'hBB;
    step();
    mem_wen = 1'b0;
    step();
    rs_d = 5'd0; mem_wen = 1'b1; mem_waddr = 5'd0; wb_waddr = 5'd0;
    step();
    clear_fwd();

    // SW, illegal opcode, illegal funct
    set_instr(6'h2B, 6'h00, 5'd0, 16'h0008, 5'd1, 5'd9, 5'd0, 32'h1000, 32'hCAFE);
    step();
    set_instr(6'h3F, 6'h00, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
    step();
    set_instr(6'h00, 6'h01, 5'd0, 16'h0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
    step();

    // Load-use: LW $t0 in E, ADD reading $t0 in ID
    set_instr(6'h23, 6'h00, 5'd0, 16'h0004, 5'd1, 5'd8, 5'd0, 32'd100, 32'd0);
    step();
    set_instr(6'h00, 6'h20, 5'd0, 16'h0, 5'd8, 5'd9, 5'd10, 32'd1, 32'd2);
    check("lu_stall_req", 32'(stall_req_o), 32'd1);
    step();
    check("lu_bubble_valid", 32'(valid_e), 32'd0);
    step();
    check("lu_issue_valid", 32'(valid_e), 32'd1);

    // External hold, then flush together with stall, then reset while stalled
    stall_i = 1'b1;
    set_instr(6'h0D, 6'h00, 5'd0, 16'h00FF, 5'd1, 5'd3, 5'd0, 32'd7, 32'd0);
    step();
    flush_i = 1'b1;
    step();
    check("flush_stall_valid", 32'(valid_e), 32'd0);
    flush_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid_stall");
    m = '0;
    @(posedge clk); #1;
    rst_n = 1'b1; stall_i = 1'b0;

    // Random mix with hazards, bubbles, holds and flushes
    for (int i = 0; i < 80; i++) begin
      valid_d   = ($urandom_range(0, 7) != 0);
      opcode_d  = r_opc[$urandom_range(0, 11)];
      funct_d   = r_funct[$urandom_range(0, 15)];
      shamt_d   = 5'($urandom);
      imm_d     = 16'($urandom);
      rs_d      = 5'($urandom_range(0, 7));
      rt_d      = 5'($urandom_range(0, 7));
      rd_d      = 5'($urandom_range(0, 7));
      rs_data_d = $urandom;
      rt_data_d = $urandom;
      mem_wen   = ($urandom_range(0, 3) == 0);
      wb_wen    = ($urandom_range(0, 3) == 0);
      mem_waddr = 5'($urandom_range(0, 7));
      wb_waddr  = 5'($urandom_range(0, 7));
      mem_wdata = $urandom;
      wb_wdata  = $urandom;
      stall_i   = ($urandom_range(0, 7) == 0);
      flush_i   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
